// File: rtl/intra_s4reffilter.sv
// Intra reference-sample smoothing: applies the [1 2 1] neighbour filter along the
// left / top-left / top chain of substituted beats, or passes them through unchanged.
module intra_s4reffilter #(
    parameter int BIT_DEPTH = 8,
    parameter int BEATW     = BIT_DEPTH * 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [BEATW-1:0]     in_data,
    input  logic [BIT_DEPTH-1:0] in_tl,
    input  logic                 in_filt,
    input  logic [2:0]           in_log2nT,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [BEATW-1:0]     out_data,
    output logic [BIT_DEPTH-1:0] out_tl,
    output logic [1:0]           dbg_state
);

    localparam int SUM_W = BIT_DEPTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [BEATW-1:0]     hold_data;
    logic [1:0]           hold_idx;
    logic [BIT_DEPTH-1:0] tl_r;
    logic                 filt_r;
    logic [2:0]           log2_r;
    logic [BIT_DEPTH-1:0] prev_raw;
    logic [BIT_DEPTH-1:0] left_last;
    logic [BIT_DEPTH-1:0] top_first;

    logic                 two_beats;
    logic [1:0]           last_left_idx;
    logic [1:0]           last_idx;
    logic [4:0]           last_pos;
    logic                 out_load;
    logic                 in_fire;
    logic                 emit_data;
    logic                 emit_flush;

    logic [BIT_DEPTH-1:0] smp [32];
    logic [BIT_DEPTH-1:0] lft [32];
    logic [BIT_DEPTH-1:0] rgt [32];
    logic [SUM_W-1:0]     tap_sum [32];
    logic [BIT_DEPTH-1:0] prev_s;
    logic [BIT_DEPTH-1:0] next_s;
    logic [BIT_DEPTH-1:0] held_last;
    logic [BIT_DEPTH-1:0] in_first;
    logic                 has_prev;
    logic                 has_next;
    logic [BEATW-1:0]     filt_beat;
    logic [SUM_W-1:0]     tl_sum;
    logic [BIT_DEPTH-1:0] tl_out;

    // Handshake: a beat moves on a side when valid and ready are both high at the
    // clock edge; valid never waits on ready, and out_* hold while valid && !ready.
    assign out_load   = !out_valid || out_ready;
    assign in_ready   = (state != S_FLUSH) && out_load;
    assign in_fire    = in_valid && in_ready;
    assign emit_data  = (state == S_HOLD) && in_fire;
    assign emit_flush = (state == S_FLUSH) && out_load;
    assign dbg_state  = state;

    // nT=32 needs two beats per side; smaller blocks use the leading 2nT samples.
    assign two_beats     = (log2_r == 3'd5);
    assign last_left_idx = two_beats ? 2'd1 : 2'd0;
    assign last_idx      = two_beats ? 2'd3 : 2'd1;

    always_comb begin
        case (log2_r)
            3'd2:    last_pos = 5'd7;
            3'd3:    last_pos = 5'd15;
            default: last_pos = 5'd31;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_fire && in_sof) state_nxt = S_HOLD;
            S_HOLD:  if (in_fire && (hold_idx + 2'd1 == last_idx)) state_nxt = S_FLUSH;
            S_FLUSH: if (out_load) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            smp[k] = hold_data[BEATW-1-k*BIT_DEPTH -: BIT_DEPTH];
        end
    end

    assign held_last = smp[last_pos];
    assign in_first  = in_data[BEATW-1 -: BIT_DEPTH];

    // The top-left sample sits between the last left beat and the first top beat.
    assign prev_s   = (hold_idx == last_left_idx + 2'd1) ? tl_r : prev_raw;
    assign next_s   = (hold_idx == last_left_idx) ? tl_r : in_first;
    assign has_prev = (hold_idx != 2'd0);
    assign has_next = (hold_idx != last_idx);

    always_comb begin
        filt_beat = hold_data;
        for (int k = 0; k < 32; k++) begin
            lft[k]     = (k == 0) ? prev_s : smp[5'(k + 31)];
            rgt[k]     = (5'(k) == last_pos) ? next_s : smp[5'(k + 1)];
            tap_sum[k] = {2'b00, lft[k]} + {1'b0, smp[k], 1'b0} + {2'b00, rgt[k]} + SUM_W'(2);
            if (filt_r && (5'(k) <= last_pos) && !(k == 0 && !has_prev) &&
                !((5'(k) == last_pos) && !has_next)) begin
                filt_beat[BEATW-1-k*BIT_DEPTH -: BIT_DEPTH] = tap_sum[k][SUM_W-1:2];
            end
        end
    end

    assign tl_sum = {2'b00, left_last} + {1'b0, tl_r, 1'b0} + {2'b00, top_first} + SUM_W'(2);
    assign tl_out = filt_r ? tl_sum[SUM_W-1:2] : tl_r;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hold_data <= '0;
            hold_idx  <= '0;
            tl_r      <= '0;
            filt_r    <= 1'b0;
            log2_r    <= '0;
            prev_raw  <= '0;
            left_last <= '0;
            top_first <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_data  <= '0;
            out_tl    <= '0;
        end else begin
            if ((state == S_IDLE) && in_fire && in_sof) begin
                hold_data <= in_data;
                hold_idx  <= 2'd0;
                tl_r      <= in_tl;
                filt_r    <= in_filt;
                log2_r    <= in_log2nT;
            end
            if (emit_data) begin
                hold_data <= in_data;
                hold_idx  <= hold_idx + 2'd1;
                prev_raw  <= held_last;
                if (hold_idx == last_left_idx) begin
                    left_last <= held_last;
                    top_first <= in_first;
                end
            end
            if (out_load) begin
                out_valid <= emit_data || emit_flush;
                out_sof   <= emit_data && (hold_idx == 2'd0);
                out_eof   <= emit_flush;
                if (emit_data || emit_flush) out_data <= filt_beat;
                if (emit_flush) out_tl <= tl_out;
            end
        end
    end

endmodule

// File: tb/tb_intra_s4reffilter.sv
// Scoreboard bench for intra_s4reffilter: a chain-level reference model feeds an
// expected queue that a monitor compares against every valid output beat.
module tb_intra_s4reffilter;

    localparam int BD    = 8;
    localparam int BEATW = BD * 32;
    localparam int QW    = BEATW + 2;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [BEATW-1:0] in_data;
    logic [BD-1:0]    in_tl;
    logic             in_filt;
    logic [2:0]       in_log2nT;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sof;
    logic             out_eof;
    logic [BEATW-1:0] out_data;
    logic [BD-1:0]    out_tl;
    logic [1:0]       dbg_state;

    logic [QW-1:0] exp_q[$];
    logic [BD-1:0] exp_tl_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beat1_acc_cyc = 0;
    int sof_out_cyc = 0;
    bit stall = 1'b0;
    bit rand_ready = 1'b0;

    intra_s4reffilter #(.BIT_DEPTH(BD)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .in_tl(in_tl), .in_filt(in_filt), .in_log2nT(in_log2nT),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .out_data(out_data), .out_tl(out_tl), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (stall)           out_ready = 1'b0;
        else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else                 out_ready = 1'b1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (arst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got sof=%b eof=%b data=%h, required no output", out_sof, out_eof, out_data);
            end else begin
                if ({out_sof, out_eof, out_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_beat: got sof=%b eof=%b data=%h, required sof=%b eof=%b data=%h",
                             out_sof, out_eof, out_data, exp_q[0][BEATW+1], exp_q[0][BEATW], exp_q[0][BEATW-1:0]);
                end
                if (exp_q[0][BEATW]) begin
                    checks++;
                    if (out_tl !== exp_tl_q[0]) begin
                        errors++;
                        $display("FAIL out_tl: got %0d, required %0d", out_tl, exp_tl_q[0]);
                    end
                end
                if (out_ready === 1'b1) begin
                    if (exp_q[0][BEATW+1]) sof_out_cyc = cyc;
                    if (exp_q[0][BEATW]) void'(exp_tl_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- model / drivers ----------------
    function automatic logic [BEATW-1:0] rand_beat();
        logic [BEATW-1:0] b;
        for (int i = 0; i < BEATW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [BEATW-1:0] put(input logic [BEATW-1:0] b, input int k, input int v);
        logic [BEATW-1:0] r;
        r = b;
        r[BEATW-1-k*BD -: BD] = BD'(v);
        return r;
    endfunction

    task automatic push_expected(input logic [BEATW-1:0] beats[4], input logic [BD-1:0] tl,
                                 input logic filt, input logic [2:0] l2);
        int nt, nb, nv, n, idx;
        int c[129];
        int f[129];
        logic [BEATW-1:0] ob;
        nt = 1 << l2;
        nb = (l2 == 3'd5) ? 2 : 1;
        nv = (2 * nt < 32) ? 2 * nt : 32;
        n = 0;
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < nv; k++) begin c[n] = int'(beats[b][BEATW-1-k*BD -: BD]); n++; end
        c[n] = int'(tl); n++;
        for (int b = nb; b < 2 * nb; b++)
            for (int k = 0; k < nv; k++) begin c[n] = int'(beats[b][BEATW-1-k*BD -: BD]); n++; end
        for (int i = 0; i < n; i++) begin
            f[i] = c[i];
            if (filt && i > 0 && i < n - 1) f[i] = ((c[i-1] + 2 * c[i] + c[i+1] + 2) >> 2) & 255;
        end
        idx = 0;
        for (int b = 0; b < 2 * nb; b++) begin
            ob = beats[b];
            if (b == nb) idx++;
            for (int k = 0; k < nv; k++) begin ob[BEATW-1-k*BD -: BD] = BD'(f[idx]); idx++; end
            exp_q.push_back({b == 0, b == 2 * nb - 1, ob});
        end
        exp_tl_q.push_back(BD'(f[nb * nv]));
    endtask

    task automatic send_beat(input logic [BEATW-1:0] d, input logic sof, input logic [BD-1:0] tl,
                             input logic filt, input logic [2:0] l2, output int acc);
        int waited;
        waited = 0;
        acc = -1;
        in_valid = 1'b1; in_data = d; in_sof = sof; in_tl = tl; in_filt = filt; in_log2nT = l2;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) begin acc = cyc; break; end
            waited++;
            if (waited > 500) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got in_ready low for %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_block(input logic [BEATW-1:0] beats[4], input logic [BD-1:0] tl,
                              input logic filt, input logic [2:0] l2, input bit gaps);
        int nb, acc, g;
        push_expected(beats, tl, filt, l2);
        nb = (l2 == 3'd5) ? 4 : 2;
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) @(posedge clk);
                if (g > 0) #1;
            end
            if (b == 0) send_beat(beats[b], 1'b1, tl, filt, l2, acc);
            else send_beat(beats[b], gaps ? 1'($urandom_range(0, 1)) : 1'b0, BD'($urandom),
                           1'($urandom), 3'($urandom_range(0, 7)), acc);
            if (b == 1) beat1_acc_cyc = acc;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; in_tl = '0;
        in_filt = 1'b0; in_log2nT = 3'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_out_sof: got %b, required 0", out_sof); end
        checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL reset_out_eof: got %b, required 0", out_eof); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        checks++; if (out_tl !== '0) begin errors++; $display("FAIL reset_out_tl: got %0d, required 0", out_tl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        logic [BEATW-1:0] bt[4];
        bt[0] = rand_beat(); bt[1] = rand_beat(); bt[2] = '0; bt[3] = '0;
        for (int k = 0; k < 16; k++) begin
            bt[0] = put(bt[0], k, 16 + 4 * k);
            bt[1] = put(bt[1], k, 84 + 4 * k);
        end
        send_block(bt, 8'd80, 1'b1, 3'd3, 1'b0);
        wait_drain("ramp");
    endtask

    task automatic test_flat32();
        logic [BEATW-1:0] bt[4];
        for (int b = 0; b < 4; b++) begin
            bt[b] = '0;
            for (int k = 0; k < 32; k++) bt[b] = put(bt[b], k, 100);
        end
        bt[1] = put(bt[1], 0, 104);
        send_block(bt, 8'd100, 1'b1, 3'd5, 1'b0);
        wait_drain("flat32");
    endtask

    task automatic test_bypass();
        logic [BEATW-1:0] bt[4];
        int lat_filt, lat_byp;
        for (int b = 0; b < 4; b++) bt[b] = rand_beat();
        send_block(bt, BD'($urandom), 1'b1, 3'd4, 1'b0);
        wait_drain("latency_filt");
        lat_filt = sof_out_cyc - beat1_acc_cyc;
        for (int b = 0; b < 4; b++) bt[b] = rand_beat();
        send_block(bt, BD'($urandom), 1'b0, 3'd4, 1'b0);
        wait_drain("bypass");
        lat_byp = sof_out_cyc - beat1_acc_cyc;
        checks++; if (lat_filt !== 1) begin errors++; $display("FAIL latency_filt: got %0d, required 1", lat_filt); end
        checks++; if (lat_byp !== 1) begin errors++; $display("FAIL latency_bypass: got %0d, required 1", lat_byp); end
    endtask

    task automatic test_endpoints();
        logic [BEATW-1:0] bt[4];
        bt[0] = put(put(rand_beat(), 0, 0), 7, 200);
        bt[1] = put(put(rand_beat(), 0, 200), 7, 255);
        bt[2] = '0; bt[3] = '0;
        send_block(bt, 8'd0, 1'b1, 3'd2, 1'b0);
        wait_drain("endpoints");
    endtask

    task automatic test_backpressure();
        logic [BEATW-1:0] ba[4];
        logic [BEATW-1:0] bb[4];
        for (int b = 0; b < 4; b++) begin ba[b] = rand_beat(); bb[b] = rand_beat(); end
        fork
            begin
                send_block(ba, BD'($urandom), 1'b1, 3'd5, 1'b0);
                send_block(bb, BD'($urandom), 1'b1, 3'd3, 1'b0);
            end
            begin
                int n;
                n = 0;
                while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
                stall = 1'b1;
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %b, required 0", in_ready);
                    end
                end
                stall = 1'b0;
            end
        join
        wait_drain("backpressure");
    endtask

    task automatic test_random();
        logic [BEATW-1:0] bt[4];
        int acc;
        send_beat(rand_beat(), 1'b0, BD'($urandom), 1'b1, 3'd3, acc);
        repeat (4) @(posedge clk);
        #1;
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) bt[b] = rand_beat();
            send_block(bt, BD'($urandom), 1'($urandom), 3'($urandom_range(2, 5)), 1'b1);
        end
        wait_drain("random");
        rand_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [BEATW-1:0] bt[4];
        int acc;
        send_beat(rand_beat(), 1'b1, BD'($urandom), 1'b1, 3'd5, acc);
        @(negedge clk);
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL midrst_pre_state: got %0d, required 1", dbg_state); end
        #2 arst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d, required 0", dbg_state); end
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) bt[b] = rand_beat();
        send_block(bt, BD'($urandom), 1'b1, 3'd5, 1'b0);
        wait_drain("midrst_next");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_flat32();
        test_bypass();
        test_endpoints();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
